// File: rtl/seq_mag_compare.sv
// -----------------------------------------------------------------------------
// seq_mag_compare
//
// Bit-serial magnitude comparator. On an accepted start the operands are
// captured and scanned one bit per clock, MSB first. The first differing bit
// resolves the result (early termination). If all bits are equal, the result
// resolves as equal after WIDTH clocks.
//
// Parameters:
//   WIDTH   operand width in bits (2..32), default 8
//
// Ports:
//   clk     input   rising-edge clock
//   rst_n   input   asynchronous active-low reset
//   start   input   compare request, accepted in IDLE or DONE
//   a, b    input   operands, captured only on an accepted start
//   busy    output  high while the scan is in progress (state SCAN)
//   done    output  one-cycle pulse, result outputs valid (state DONE)
//   red     output  registered A >= B
//   green   output  registered A <= B
//   blue    output  registered A != B
//
// Build option:
//   SEQ_CMP_SIGNED_EN  when defined, operands compare as two's-complement
//                      (a differing MSB resolves inverted). Undefined gives
//                      a plain unsigned compare.
// -----------------------------------------------------------------------------
module seq_mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             red,
  output logic             green,
  output logic             blue
);

  localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_MSB  = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef SEQ_CMP_SIGNED_EN
  localparam logic SIGNED_CMP = 1'b1;
`else
  localparam logic SIGNED_CMP = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             red_q, red_d;
  logic             green_q, green_d;
  logic             blue_q, blue_d;

  logic bit_a;
  logic bit_b;
  logic bits_differ;
  logic msb_invert;
  logic a_greater;

  assign bit_a       = a_q[idx_q];
  assign bit_b       = b_q[idx_q];
  assign bits_differ = bit_a ^ bit_b;

  // In the signed build the sign bit carries negative weight, so a set MSB
  // on A means A is the smaller operand: flip the sense of the decision.
  assign msb_invert  = SIGNED_CMP & (idx_q == IDX_MSB);
  assign a_greater   = bit_a ^ msb_invert;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_MSB;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SCAN: begin
        if (bits_differ) begin
          // Highest differing bit decides; lower bits are never examined.
          red_d   = a_greater;
          green_d = ~a_greater;
          blue_d  = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == IDX_ZERO) begin
          red_d   = 1'b1;
          green_d = 1'b1;
          blue_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_MSB;
      a_q     <= '0;
      b_q     <= '0;
      red_q   <= 1'b0;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign busy  = (state_q == S_SCAN);
  assign done  = (state_q == S_DONE);
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: tb/tb_seq_mag_compare.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_compare
//
// Scoreboard bench for seq_mag_compare (WIDTH=8). Each driven comparison
// pushes its expected {red,green,blue}, latency and accept edge; a negedge
// monitor pops an entry on every done pulse and checks result, latency and
// the number of busy cycles that preceded it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_mag_compare;

  localparam int W = 8;

  typedef struct {
    logic [2:0] rgb;
    int         lat;
    int         start_edge;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         red;
  logic         green;
  logic         blue;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   done_cnt;
  int   busy_cnt;

  seq_mag_compare #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: arithmetic compare for the result, highest differing bit
  // for the latency.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic gt;
    logic found;
    found = 1'b0;
    e.lat = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && av[i] != bv[i]) begin
        e.lat = W - i;
        found = 1'b1;
      end
    end
`ifdef SEQ_CMP_SIGNED_EN
    gt = ($signed(av) > $signed(bv));
`else
    gt = (av > bv);
`endif
    if (av == bv) e.rgb = 3'b110;
    else if (gt)  e.rgb = 3'b101;
    else          e.rgb = 3'b011;
    e.start_edge = 0;
    return e;
  endfunction

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check_val("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("txn %0d: rgb=%b exp=%b lat=%0d busy=%0d", done_cnt,
                   {red, green, blue}, e.rgb, cyc - e.start_edge, busy_cnt);
          check_val("rgb", {29'd0, red, green, blue}, {29'd0, e.rgb});
          check_val("latency", cyc - e.start_edge, e.lat);
          check_val("busy_cycles", busy_cnt, e.lat);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_done(input int base, input int want, input int budget);
    int k;
    k = 0;
    while (done_cnt < base + want && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("done_pulses", done_cnt - base, want);
  endtask

  // Single comparison; with noise set, start/a/b are scrambled while busy.
  task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise);
    exp_t e;
    int   base;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    e = model(av, bv);
    e.start_edge = cyc + 1;
    exp_q.push_back(e);
    base = done_cnt;
    for (int k = 0; k < e.lat; k++) begin
      @(negedge clk);
      if (noise) begin
        start = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(base, 1, 4);
  endtask

  task automatic back_to_back(input logic [3*W-1:0] as, input logic [3*W-1:0] bs);
    exp_t e;
    int   base;
    int   prev_se;
    int   prev_lat;
    int   guard;
    base = done_cnt;
    prev_se = 0;
    prev_lat = 0;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        guard = 0;
        while (cyc < prev_se && guard < 40) begin
          @(negedge clk);
          guard++;
        end
      end
      a = as[j*W +: W];
      b = bs[j*W +: W];
      start = 1'b1;
      e = model(a, b);
      // Held start re-captures on the edge that leaves DONE.
      e.start_edge = (j == 0) ? cyc + 1 : prev_se + prev_lat + 1;
      exp_q.push_back(e);
      prev_se = e.start_edge;
      prev_lat = e.lat;
    end
    guard = 0;
    while (cyc < prev_se && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    wait_done(base, 3, 40);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    busy_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #3;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_rgb", {29'd0, red, green, blue}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmp(8'h80, 8'h7F, 1'b0);
    do_cmp(8'h05, 8'h05, 1'b0);
    do_cmp(8'h12, 8'h13, 1'b1);
    do_cmp(8'h80, 8'h01, 1'b0);
    do_cmp(8'h3C, 8'h5A, 1'b0);
    do_cmp(8'hFF, 8'hFE, 1'b0);
    for (int r = 0; r < 4; r++) begin
      do_cmp(W'($urandom), W'($urandom), 1'b0);
    end

    // Abort a scan with an asynchronous reset just after edge 3.
    @(negedge clk);
    a = 8'h05;
    b = 8'h05;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_rgb", {29'd0, red, green, blue}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("abort_no_done", {31'd0, done}, 32'd0);
    do_cmp(8'h02, 8'h01, 1'b0);

    back_to_back({8'h44, 8'h00, 8'hA0}, {8'h44, 8'h01, 8'h20});

    repeat (4) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 32'd0);
    check_val("idle_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
